// File: rtl/dac_soft_ramp.sv
`timescale 1ns/1ps
// dac_soft_ramp: soft gain ramp between dac_buffer_reg and multi_dac_interface.
// Scales each 24-bit signed sample of a frame by an unsigned Q1.15 gain, one
// channel per cycle through a single multiplier. The gain ramps 0 -> unity on
// start and unity -> 0 on stop/underrun so the coil drivers never see a step.
// Optional feature macro: DAC_SOFT_RAMP_ROUND_EN (round-half-up instead of
// truncation toward -inf). dac_channels must be at least 2.
module dac_soft_ramp #(
    parameter int          dac_channels = 4,
    parameter logic [15:0] RAMP_STEP    = 16'h0080
) (
    input  logic                      capture_clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [32*dac_channels-1:0] in_buffer,
    output logic                      in_request,
    input  logic                      in_underrun,
    output logic [32*dac_channels-1:0] out_buffer,
    input  logic                      out_request,
    output logic                      out_enable,
    output logic [1:0]                ramp_state,
    output logic [15:0]               gain,
    output logic                      underrun_latched
);

    localparam int               FW         = 32 * dac_channels;
    localparam int               CNT_W      = $clog2(dac_channels + 2) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(dac_channels);
    localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(dac_channels + 1);
    localparam logic [15:0]      GAIN_UNITY = 16'h8000;
`ifdef DAC_SOFT_RAMP_ROUND_EN
    localparam logic signed [40:0] RND = 41'sd16384;
`else
    localparam logic signed [40:0] RND = 41'sd0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_UNITY     = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [FW-1:0]      r_frame;
    logic [FW-1:0]      r_res;
    logic [FW-1:0]      r_out;
    logic [15:0]        r_gain;
    logic [15:0]        w_gain_next;
    logic [16:0]        w_gain_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_in_req;
    logic               r_out_en;
    logic               r_unf;
    logic               w_stop;
    logic               w_accept;
    logic               w_capture;
    logic               w_proc;
    logic               w_load;
    logic               w_done;
    logic signed [40:0] w_sample_x;
    logic signed [40:0] w_gain_x;
    logic signed [40:0] w_prod;
    logic signed [40:0] w_sum;
    logic [23:0]        w_result;
    logic               w_unused;

    // Frame sequencing: a frame occupies the block from accept until the
    // cycle after out_buffer is loaded; requests inside that window are ignored.
    assign w_stop    = !enable || in_underrun;
    assign w_accept  = out_request && !r_busy && (r_state != ST_IDLE);
    assign w_capture = w_accept && (w_state_next != ST_RAMP_DOWN);
    assign w_proc    = r_busy && (r_cnt < CNT_LOAD);
    assign w_load    = r_busy && (r_cnt == CNT_LOAD);
    assign w_done    = r_busy && (r_cnt == CNT_DONE);

    // Single shared multiplier; the channel under work always sits in r_frame[23:0].
    assign w_sample_x = $signed({{17{r_frame[23]}}, r_frame[23:0]});
    assign w_gain_x   = $signed({25'd0, r_gain});
    assign w_prod     = w_sample_x * w_gain_x;
    assign w_sum      = w_prod + RND;
    assign w_result   = w_sum[38:15];
    assign w_unused   = ^{w_sum[40:39], w_sum[14:0]};

    // Next ramp state: stop/underrun wins in RAMP_UP/UNITY, ramp-down always completes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && !r_unf) w_state_next = ST_RAMP_UP;
                else                  w_state_next = ST_IDLE;
            end
            ST_RAMP_UP: begin
                if (w_stop)                                     w_state_next = ST_RAMP_DOWN;
                else if (w_load && (w_gain_next == GAIN_UNITY)) w_state_next = ST_UNITY;
                else                                            w_state_next = ST_RAMP_UP;
            end
            ST_UNITY: begin
                if (w_stop) w_state_next = ST_RAMP_DOWN;
                else        w_state_next = ST_UNITY;
            end
            ST_RAMP_DOWN: begin
                if (w_load && (r_gain == 16'h0000)) w_state_next = ST_IDLE;
                else                                w_state_next = ST_RAMP_DOWN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Per-frame gain step: saturate at unity going up, clamp at zero going down.
    always_comb begin
        w_gain_sum  = {1'b0, r_gain} + {1'b0, RAMP_STEP};
        w_gain_next = r_gain;
        case (r_state)
            ST_RAMP_UP: begin
                if (w_gain_sum >= 17'h08000) w_gain_next = GAIN_UNITY;
                else                         w_gain_next = w_gain_sum[15:0];
            end
            ST_RAMP_DOWN: begin
                if (r_gain <= RAMP_STEP) w_gain_next = 16'h0000;
                else                     w_gain_next = r_gain - RAMP_STEP;
            end
            default: w_gain_next = r_gain;
        endcase
    end

    // Ramp state register.
    always_ff @(posedge capture_clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Frame capture, per-channel rotation and result collection.
    always_ff @(posedge capture_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_frame <= '0;
            r_res   <= '0;
        end else begin
            if (w_accept) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end else if (w_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (r_busy) begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt  <= r_cnt;
            end
            // Rotation returns the frame to its original order after all
            // channels, so a held frame can be re-scaled during ramp-down.
            if (w_capture)   r_frame <= in_buffer;
            else if (w_proc) r_frame <= {r_frame[31:0], r_frame[FW-1:32]};
            else             r_frame <= r_frame;
            if (w_proc) r_res <= {8'h00, w_result, r_res[FW-1:32]};
            else        r_res <= r_res;
        end
    end

    // Registered outputs: gain, frame, enable, request pulse and sticky underrun.
    always_ff @(posedge capture_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gain   <= 16'h0000;
            r_out    <= '0;
            r_out_en <= 1'b0;
            r_in_req <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) r_gain <= 16'h0000;
            else if (w_load)        r_gain <= w_gain_next;
            else                    r_gain <= r_gain;
            if (w_state_next == ST_IDLE) r_out <= '0;
            else if (w_load)             r_out <= r_res;
            else                         r_out <= r_out;
            r_out_en <= (w_state_next != ST_IDLE);
            r_in_req <= w_capture;
            if (in_underrun)  r_unf <= 1'b1;
            else if (!enable) r_unf <= 1'b0;
            else              r_unf <= r_unf;
        end
    end

    assign in_request       = r_in_req;
    assign out_buffer       = r_out;
    assign out_enable       = r_out_en;
    assign ramp_state       = r_state;
    assign gain             = r_gain;
    assign underrun_latched = r_unf;

endmodule

// File: tb/tb_dac_soft_ramp.sv
`timescale 1ns/1ps
// Directed bench for dac_soft_ramp with 4 channels and a 16'h2000 ramp step.
module tb_dac_soft_ramp;

    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [127:0] in_buffer;
    logic         in_request;
    logic         in_underrun;
    logic [127:0] out_buffer;
    logic         out_request;
    logic         out_enable;
    logic [1:0]   ramp_state;
    logic [15:0]  gain;
    logic         underrun_latched;

    int checks = 0;
    int errors = 0;
    int p;

    logic [23:0] ramp_exp  [5] = '{24'h000000, 24'h040000, 24'h080000, 24'h0C0000, 24'h100000};
    logic [15:0] ramp_gain [5] = '{16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'h8000};
    logic [1:0]  ramp_st   [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [23:0] down_exp  [5] = '{24'h100000, 24'h0C0000, 24'h080000, 24'h040000, 24'h000000};
    logic [15:0] down_gain [5] = '{16'h6000, 16'h4000, 16'h2000, 16'h0000, 16'h0000};
    logic [23:0] neg1_g2, neg1_g4;

    dac_soft_ramp #(.dac_channels(NCH), .RAMP_STEP(16'h2000)) dut (
        .capture_clk      (clk),
        .reset_n          (rst_n),
        .enable           (enable),
        .in_buffer        (in_buffer),
        .in_request       (in_request),
        .in_underrun      (in_underrun),
        .out_buffer       (out_buffer),
        .out_request      (out_request),
        .out_enable       (out_enable),
        .ramp_state       (ramp_state),
        .gain             (gain),
        .underrun_latched (underrun_latched)
    );

    // Free-running capture clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] frm(input logic [23:0] a3, input logic [23:0] a2,
                                         input logic [23:0] a1, input logic [23:0] a0);
        return {8'h00, a3, 8'h00, a2, 8'h00, a1, 8'h00, a0};
    endfunction

    // One out_request pulse, then run to T+NCH+3 counting in_request pulses.
    task automatic do_frame(output int pulses);
        pulses = 0;
        out_request = 1'b1;
        tick();
        out_request = 1'b0;
        if (in_request) pulses++;
        for (int i = 0; i < NCH + 2; i++) begin
            tick();
            if (in_request) pulses++;
        end
    endtask

    initial begin
`ifdef DAC_SOFT_RAMP_ROUND_EN
        neg1_g2 = 24'h000000;
        neg1_g4 = 24'h000000;
`else
        neg1_g2 = 24'hFFFFFF;
        neg1_g4 = 24'hFFFFFF;
`endif
        rst_n = 1'b0; enable = 1'b0; in_underrun = 1'b0; out_request = 1'b0; in_buffer = '0;
        tick(); tick();
        chk("rst_out", out_buffer, 128'd0);
        chk("rst_oen", 128'(out_enable), 128'd0);
        chk("rst_state", 128'(ramp_state), 128'd0);
        chk("rst_gain", 128'(gain), 128'd0);
        chk("rst_unf", 128'(underrun_latched), 128'd0);
        chk("rst_inreq", 128'(in_request), 128'd0);
        rst_n = 1'b1;
        tick();

        // Ramp up from zero to unity.
        enable = 1'b1;
        in_buffer = {4{32'hAB100000}};
        chk("oen_same_cycle", 128'(out_enable), 128'd0);
        tick();
        chk("oen_rise", 128'(out_enable), 128'd1);
        chk("state_up", 128'(ramp_state), 128'd1);
        chk("gain_start", 128'(gain), 128'd0);
        for (int f = 0; f < 5; f++) begin
            do_frame(p);
            chk($sformatf("up_out%0d", f), out_buffer,
                frm(ramp_exp[f], ramp_exp[f], ramp_exp[f], ramp_exp[f]));
            chk($sformatf("up_gain%0d", f), 128'(gain), 128'(ramp_gain[f]));
            chk($sformatf("up_state%0d", f), 128'(ramp_state), 128'(ramp_st[f]));
            chk($sformatf("up_inreq%0d", f), 128'(p), 128'd1);
        end

        // Unity passes distinct samples bit-exact and in channel order.
        in_buffer = {32'hAB123456, 32'hAB000001, 32'hAB800000, 32'hAB7FFFFF};
        do_frame(p);
        chk("unity_pass", out_buffer, frm(24'h123456, 24'h000001, 24'h800000, 24'h7FFFFF));

        // Underrun while at unity.
        in_buffer = {4{32'h00100000}};
        do_frame(p);
        chk("unf_pre", out_buffer, frm(24'h100000, 24'h100000, 24'h100000, 24'h100000));
        in_underrun = 1'b1;
        tick();
        in_underrun = 1'b0;
        chk("unf_state", 128'(ramp_state), 128'd3);
        chk("unf_latch", 128'(underrun_latched), 128'd1);
        in_buffer = {4{32'h00200000}};
        for (int f = 0; f < 5; f++) begin
            do_frame(p);
            chk($sformatf("dn_out%0d", f), out_buffer,
                frm(down_exp[f], down_exp[f], down_exp[f], down_exp[f]));
            chk($sformatf("dn_gain%0d", f), 128'(gain), 128'(down_gain[f]));
            chk($sformatf("dn_inreq%0d", f), 128'(p), 128'd0);
        end
        chk("dn_idle", 128'(ramp_state), 128'd0);
        chk("dn_oen", 128'(out_enable), 128'd0);
        tick(); tick(); tick();
        chk("unf_hold_idle", 128'(ramp_state), 128'd0);
        enable = 1'b0;
        tick();
        chk("unf_clear", 128'(underrun_latched), 128'd0);
        enable = 1'b1;
        tick();
        chk("restart_state", 128'(ramp_state), 128'd1);
        chk("restart_oen", 128'(out_enable), 128'd1);

        // Ramp up with mixed samples, then disable at gain 4000.
        in_buffer = {32'h00200000, 32'h00FFFF00, 32'h00000100, 32'h00FFFFFF};
        do_frame(p);
        chk("mix_g0", out_buffer, 128'd0);
        do_frame(p);
        chk("mix_g2", out_buffer, frm(24'h080000, 24'hFFFFC0, 24'h000040, neg1_g2));
        chk("mix_gain4", 128'(gain), 128'h4000);
        enable = 1'b0;
        tick();
        chk("dis_state", 128'(ramp_state), 128'd3);
        in_buffer = '0;
        do_frame(p);
        chk("dis_g4", out_buffer, frm(24'h100000, 24'hFFFF80, 24'h000080, neg1_g4));
        chk("dis_gain2", 128'(gain), 128'h2000);
        chk("dis_inreq", 128'(p), 128'd0);
        do_frame(p);
        chk("dis_g2", out_buffer, frm(24'h080000, 24'hFFFFC0, 24'h000040, neg1_g2));
        chk("dis_gain0", 128'(gain), 128'h0000);
        do_frame(p);
        chk("dis_out0", out_buffer, 128'd0);
        chk("dis_idle", 128'(ramp_state), 128'd0);
        chk("dis_oen", 128'(out_enable), 128'd0);

        // Overlapping request two cycles after the first.
        enable = 1'b1;
        tick();
        in_buffer = {4{32'h00100000}};
        do_frame(p);
        chk("ovl_pre_gain", 128'(gain), 128'h2000);
        out_request = 1'b1;
        tick();
        out_request = 1'b0;
        p = 0;
        for (int c = 1; c <= 12; c++) begin
            if (in_request) p++;
            if (c == 1) chk("ovl_inreq_t1", 128'(in_request), 128'd1);
            if (c == 2) out_request = 1'b1;
            if (c == 3) out_request = 1'b0;
            if (c == NCH + 1) chk("ovl_not_yet", out_buffer, 128'd0);
            if (c == NCH + 2) begin
                chk("ovl_update", out_buffer, frm(24'h040000, 24'h040000, 24'h040000, 24'h040000));
                chk("ovl_gain_upd", 128'(gain), 128'h4000);
            end
            tick();
        end
        chk("ovl_one_inreq", 128'(p), 128'd1);
        chk("ovl_one_update", 128'(gain), 128'h4000);

        // Asynchronous reset in the middle of a frame.
        out_request = 1'b1;
        tick();
        out_request = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out", out_buffer, 128'd0);
        chk("mrst_gain", 128'(gain), 128'd0);
        chk("mrst_state", 128'(ramp_state), 128'd0);
        chk("mrst_oen", 128'(out_enable), 128'd0);
        chk("mrst_inreq", 128'(in_request), 128'd0);
        chk("mrst_unf", 128'(underrun_latched), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
